dmem_store_responder: RTL and testbench

Data-memory end of the single-cycle CPU's store bus. Consumes `memwrite`, `dataadr`, `writedata` and returns `readdata` as a word-addressed RAM with asynchronous read. Every accepted store is also captured in a store-log FIFO. A testbench or checker drains the log through a valid/ready port, so stores are observed without probing CPU internals.

---
 rtl/dmem_store_responder.sv | 95 +++++++++
 tb/tb_dmem_store_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_responder.sv
// Word-addressed data RAM for the single-cycle CPU store bus, with asynchronous read.
// Every accepted store is also captured in a store-log FIFO that is drained through valid/ready.
module dmem_store_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LOG_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memwrite,
    input  logic [31:0]                  dataadr,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [31:0]                  log_addr,
    output logic [31:0]                  log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic [15:0]                  drop_count,
    output logic                         misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(LOG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(LOG_DEPTH);

    logic [31:0]   ram      [DEPTH_WORDS];
    logic [31:0]   log_amem [LOG_DEPTH];
    logic [31:0]   log_dmem [LOG_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] index;
    logic          store_req;
    logic          log_full;
    logic          pop;
    logic          push;
    logic          drop;

    assign index     = dataadr[AW+1:2];
    assign readdata  = ram[index];

    assign store_req = memwrite && (dataadr[1:0] == 2'b00);
    assign log_valid = (log_count != '0);
    assign log_full  = (log_count == FULL_COUNT);
    assign pop       = log_valid && log_ready;
    // A pop in the same cycle frees the slot, so a full log can still accept a push.
    assign push      = store_req && (!log_full || pop);
    assign drop      = store_req && log_full && !pop;

    assign log_addr  = log_valid ? log_amem[rd_ptr] : 32'd0;
    assign log_data  = log_valid ? log_dmem[rd_ptr] : 32'd0;

    // RAM and log storage are deliberately left out of reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (reset && store_req) begin
            ram[index] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            log_amem[wr_ptr] <= dataadr;
            log_dmem[wr_ptr] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            log_count  <= '0;
            drop_count <= '0;
            misaligned <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   log_count <= log_count + CW'(1);
                2'b01:   log_count <= log_count - CW'(1);
                default: log_count <= log_count;
            endcase
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (memwrite && (dataadr[1:0] != 2'b00)) begin
                misaligned <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_responder.sv
// Directed self-checking bench for dmem_store_responder: loads/stores, aliasing,
// log fill/drop/drain, full-with-pop, misaligned stores and mid-drain reset.
module tb_dmem_store_responder;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [3:0]  log_count;
    logic [15:0] drop_count;
    logic        misaligned;

    int total_checks = 0;
    int bad_checks   = 0;

    dmem_store_responder #(
        .DEPTH_WORDS(64),
        .LOG_DEPTH  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_addr  (log_addr),
        .log_data  (log_data),
        .log_count (log_count),
        .drop_count(drop_count),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the task returns mid-low-phase, so checks
    // made right after it see the state left by the previous rising edge.
    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] data, input logic rdy,
                                 input logic rst);
        @(negedge clk);
        memwrite  = we;
        dataadr   = adr;
        writedata = data;
        log_ready = rdy;
        reset     = rst;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        reset     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = 32'd0;
        writedata = 32'd0;
        log_ready = 1'b0;

        // Reset for two edges
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("rst_count", 32'(log_count), 32'd0);
        checkOutput("rst_valid", 32'(log_valid), 32'd0);
        checkOutput("rst_addr", log_addr, 32'd0);
        checkOutput("rst_data", log_data, 32'd0);
        checkOutput("rst_drop", 32'(drop_count), 32'd0);
        checkOutput("rst_misal", 32'(misaligned), 32'd0);

        // Basic store/load with no log fall-through
        applyStimulus(1'b1, 32'h54, 32'h7, 1'b0, 1'b1);
        checkOutput("basic_valid_pre", 32'(log_valid), 32'd0);
        applyStimulus(1'b0, 32'h54, 32'h0, 1'b0, 1'b1);
        checkOutput("basic_read", readdata, 32'h7);
        checkOutput("basic_valid", 32'(log_valid), 32'd1);
        checkOutput("basic_count", 32'(log_count), 32'd1);
        checkOutput("basic_laddr", log_addr, 32'h54);
        checkOutput("basic_ldata", log_data, 32'h7);
        applyStimulus(1'b0, 32'h54, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h54, 32'h0, 1'b0, 1'b1);
        checkOutput("basic_count_drained", 32'(log_count), 32'd0);

        // Alias modulo 256 bytes and read-before-write
        applyStimulus(1'b1, 32'h10, 32'hAAAA_AAAA, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h110, 32'h5555_5555, 1'b0, 1'b1);
        checkOutput("alias_old", readdata, 32'hAAAA_AAAA);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
        checkOutput("alias_new", readdata, 32'h5555_5555);
        checkOutput("alias_count", 32'(log_count), 32'd2);
        checkOutput("alias_addr0", log_addr, 32'h10);
        checkOutput("alias_data0", log_data, 32'hAAAA_AAAA);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
        checkOutput("alias_addr1", log_addr, 32'h110);
        checkOutput("alias_data1", log_data, 32'h5555_5555);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
        checkOutput("alias_empty", 32'(log_count), 32'd0);

        // Fill past capacity with no consumer
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 32'(i * 4), 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("full_count", 32'(log_count), 32'd8);
        checkOutput("full_drop", 32'(drop_count), 32'd2);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
            checkOutput($sformatf("drain_addr%0d", j), log_addr, 32'(j * 4));
            checkOutput($sformatf("drain_data%0d", j), log_data, 32'(j * 4));
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("drain_valid", 32'(log_valid), 32'd0);
        checkOutput("drain_addr", log_addr, 32'd0);
        checkOutput("drain_data", log_data, 32'd0);
        checkOutput("drain_drop", 32'(drop_count), 32'd2);

        // Full log with a simultaneous pop still accepts the push
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h80 + 32'(i * 4), 32'(i), 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 32'h40, 32'h99, 1'b1, 1'b1);
        checkOutput("fpop_count_pre", 32'(log_count), 32'd8);
        applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
        checkOutput("fpop_count", 32'(log_count), 32'd8);
        checkOutput("fpop_drop", 32'(drop_count), 32'd2);
        checkOutput("fpop_ram", readdata, 32'h99);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
            if (j < 7) begin
                checkOutput($sformatf("fpop_addr%0d", j), log_addr, 32'h84 + 32'(j * 4));
                checkOutput($sformatf("fpop_data%0d", j), log_data, 32'(j + 1));
            end else begin
                checkOutput("fpop_addr_last", log_addr, 32'h40);
                checkOutput("fpop_data_last", log_data, 32'h99);
            end
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("fpop_empty", 32'(log_count), 32'd0);

        // Misaligned store is neither written nor logged, and sets the sticky flag
        applyStimulus(1'b1, 32'h20, 32'h1234, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h20, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h22, 32'hDEAD, 1'b0, 1'b1);
        checkOutput("mis_flag_pre", 32'(misaligned), 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
        checkOutput("mis_ram", readdata, 32'h1234);
        checkOutput("mis_count", 32'(log_count), 32'd0);
        checkOutput("mis_flag", 32'(misaligned), 32'd1);
        checkOutput("mis_drop", 32'(drop_count), 32'd2);
        applyStimulus(1'b1, 32'h24, 32'h77, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
        checkOutput("mis_after_read", readdata, 32'h77);
        checkOutput("mis_after_count", 32'(log_count), 32'd1);
        checkOutput("mis_after_addr", log_addr, 32'h24);
        checkOutput("mis_flag_sticky", 32'(misaligned), 32'd1);

        // Reset while three entries are pending and a store is presented
        applyStimulus(1'b1, 32'h30, 32'h00C0_FFEE, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h28, 32'h1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("mid_count_pre", 32'(log_count), 32'd3);
        applyStimulus(1'b1, 32'h30, 32'h0000_0BAD, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h30, 32'h0, 1'b0, 1'b1);
        checkOutput("mid_count", 32'(log_count), 32'd0);
        checkOutput("mid_valid", 32'(log_valid), 32'd0);
        checkOutput("mid_drop", 32'(drop_count), 32'd0);
        checkOutput("mid_misal", 32'(misaligned), 32'd0);
        checkOutput("mid_ram12", readdata, 32'h00C0_FFEE);
        applyStimulus(1'b0, 32'h54, 32'h0, 1'b0, 1'b1);
        checkOutput("mid_ram_54", readdata, 32'h7);
        applyStimulus(1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
        checkOutput("mid_ram_24", readdata, 32'h77);
        applyStimulus(1'b1, 32'h8, 32'h5, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h8, 32'h0, 1'b0, 1'b1);
        checkOutput("post_count", 32'(log_count), 32'd1);
        checkOutput("post_addr", log_addr, 32'h8);
        checkOutput("post_read", readdata, 32'h5);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
